// File: rtl/rs_enc_ctrl.sv
// Frame sequencer for a GF(32) RS(N,K) systematic encoder: forwards K message
// symbols while feeding the external parity LFSR, then shifts out N-K parity symbols.
module rs_enc_ctrl #(
    parameter int N     = 31,
    parameter int K     = 27,
    parameter int SYM_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic [SYM_W-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_data,
    output logic             out_sop,
    output logic             out_eop,
    output logic             lfsr_en,
    output logic             lfsr_fb_en,
    output logic [SYM_W-1:0] lfsr_din,
    output logic             lfsr_clr,
    input  logic [SYM_W-1:0] par_sym,
    output logic             busy,
    output logic             err_frame
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(K);
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(N - K);

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
    logic               slot, acc;
    logic               load, load_sop, load_eop, err_set;
    logic [SYM_W-1:0]   load_data;

    // The output register is free when empty or being drained this cycle.
    assign slot     = !out_valid || out_ready;
    assign in_ready = slot && (state != PARITY);
    assign acc      = in_valid && in_ready;
    assign cnt_inc  = cnt + CNT_W'(1);
    assign lfsr_din = in_data;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (acc && in_sop) begin
                    if (K == 1) begin
                        state_nxt = PARITY;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = DATA;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (acc) begin
                    if (cnt_inc == K_LAST) begin
                        state_nxt = PARITY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            PARITY: begin
                if (slot) begin
                    if (cnt_inc == P_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // The LFSR advances exactly once per symbol that enters the output register.
    always_comb begin
        lfsr_en    = 1'b0;
        lfsr_fb_en = 1'b0;
        lfsr_clr   = 1'b0;
        load       = 1'b0;
        load_sop   = 1'b0;
        load_eop   = 1'b0;
        load_data  = in_data;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (acc) begin
                    if (in_sop) begin
                        load       = 1'b1;
                        load_sop   = 1'b1;
                        lfsr_en    = 1'b1;
                        lfsr_fb_en = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            DATA: begin
                if (acc) begin
                    load       = 1'b1;
                    lfsr_en    = 1'b1;
                    lfsr_fb_en = 1'b1;
                end
            end
            PARITY: begin
                if (slot) begin
                    load      = 1'b1;
                    load_data = par_sym;
                    lfsr_en   = 1'b1;
                    if (cnt_inc == P_LAST) begin
                        load_eop = 1'b1;
                        lfsr_clr = 1'b1;
                    end
                end
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            if (slot) begin
                out_valid <= load;
                if (load) begin
                    out_data <= load_data;
                    out_sop  <= load_sop;
                    out_eop  <= load_eop;
                end
            end
            err_frame <= err_set;
        end
    end

endmodule
